ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYC, default 6000, clock-low inhibit time in clk_i cycles (120 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 750000, maximum wait for any device clock edge (15 ms at 50 MHz).
REQ-003 SHALL have port clk_i  input  1  single clock, 50 MHz.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_data_i  input  8  command byte to send to keyboard.
REQ-006 SHALL have port cmd_valid_i  input  1  command request.
REQ-007 SHALL have port cmd_ready_o  output  1  high only in IDLE; a transfer is accepted when cmd_valid_i and cmd_ready_o are both high.
REQ-008 SHALL have port ps2_clk_i  input  1  raw PS2_CLK line level.
REQ-009 SHALL have port ps2_dat_i  input  1  raw PS2_DAT line level.
REQ-010 SHALL have port ps2_clk_oe_o  output  1  1 = drive PS2_CLK low, 0 = release.
REQ-011 SHALL have port ps2_dat_oe_o  output  1  1 = drive PS2_DAT low, 0 = release.
REQ-012 SHALL have port busy_o  output  1  high in every state except IDLE; the receiver ignores the line while it is high.
REQ-013 SHALL have port done_o  output  1  one-cycle pulse on successful transfer with device ACK.
REQ-014 SHALL have port error_o  output  1  one-cycle pulse on timeout or missing ACK.

Function
REQ-015 SHALL pass ps2_clk_i and ps2_dat_i through a 2-FF synchronizer; a falling edge is synced clock at 1 in cycle n-1 and 0 in cycle n.
REQ-016 SHALL implement the states IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACK and WAIT_IDLE.
REQ-017 On accept in IDLE it SHALL latch cmd_data_i, compute the odd parity bit (~^data), and enter INHIBIT.
REQ-018 INHIBIT SHALL drive ps2_clk_oe_o=1 for exactly INHIBIT_CYC cycles; ps2_dat_oe_o=1 SHALL assert during the final cycle (start bit); then the state is REQ.
REQ-019 REQ SHALL release the clock (ps2_clk_oe_o=0) and hold data low; the first device falling edge SHALL move to DATA and present bit0.
REQ-020 DATA SHALL present data LSB first, ps2_dat_oe_o = ~bit; each falling edge advances one bit; the falling edge after bit7 SHALL present parity and enter PARITY.
REQ-021 The next falling edge SHALL release data (stop bit) and enter STOP; the next SHALL enter ACK.
REQ-022 On entering ACK the block SHALL sample synced data: 0 -> proceed to WAIT_IDLE with ack ok; 1 -> error_o pulse, go to WAIT_IDLE with ack failed.
REQ-023 WAIT_IDLE SHALL wait until synced clock and data are both 1, then return to IDLE; done_o SHALL pulse on that transition only if ack was ok.
REQ-024 A timeout counter SHALL clear on every falling edge and on state entry; reaching TIMEOUT_CYC in REQ/DATA/PARITY/STOP/ACK/WAIT_IDLE SHALL release both lines, pulse error_o, and return to IDLE.
REQ-025 cmd_valid_i while busy SHALL be ignored and no queueing SHALL occur.
REQ-026 done_o and error_o SHALL never pulse in the same cycle, and exactly one of them SHALL pulse per accepted command.
REQ-027 Counter widths SHALL be $clog2 of the respective parameter plus 1; no wrap-around is permitted.

Reset
REQ-028 rst_i SHALL force IDLE asynchronously and clear all counters.
REQ-029 On reset, outputs SHALL be ps2_clk_oe_o=0, ps2_dat_oe_o=0, cmd_ready_o=1, busy_o=0, done_o=0, error_o=0.
REQ-030 Reset mid-transfer SHALL release both lines in the same cycle, with no done_o/error_o pulse.

Structure
REQ-031 Package ps2_pkg SHALL hold the state enum, default INHIBIT_CYC/TIMEOUT_CYC constants and the common command codes (0xED set LEDs, 0xF4 enable, 0xFF reset).
REQ-032 Sub-module ps2_sync_edge SHALL contain the 2-FF synchronizer and falling-edge detector, instantiated once per line.

Verification
REQ-033 Send 0xED with a device model ACK -> ps2_clk_oe_o low 6000 cycles, data bits 1,0,1,1,0,1,1,1, parity 1, stop released, done_o single pulse.
REQ-034 Send 0xF4 -> parity bit 0 on the 9th edge, done_o pulse, cmd_ready_o high after lines idle.
REQ-035 Device never clocks after REQ -> error_o pulse exactly TIMEOUT_CYC cycles after REQ entry, both oe outputs 0, IDLE.
REQ-036 Device leaves data high at ACK -> error_o pulse, no done_o, return to IDLE after lines high.
REQ-037 Assert rst_i during DATA bit3 -> both oe outputs 0 immediately, busy_o 0, no pulse; next command 0x00 completes with parity 1.
REQ-038 Hold cmd_valid_i with 0xFF for the whole transfer -> exactly one transfer accepted, then a second accepted only after done_o.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared state encoding, timing defaults and keyboard command codes for the
// PS/2 host transmit path.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_state_e;

  localparam int PS2_INHIBIT_CYC_DEF = 6000;
  localparam int PS2_TIMEOUT_CYC_DEF = 750000;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one open-drain PS/2 line plus falling-edge detect.
module ps2_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_sync,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Idle bus level is high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clock out
// eight data bits, odd parity and stop, then check the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = PS2_INHIBIT_CYC_DEF,
  parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] cmd_data_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_dat_oe_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  localparam int INH_W = $clog2(INHIBIT_CYC) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [INH_W-1:0] INH_START = INH_W'(INHIBIT_CYC - 2);
  localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  ps2_state_e       r_state;
  logic [INH_W-1:0] r_inh_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [2:0]       r_bit;
  logic             r_ack_ok;
  logic [7:0]       r_data;
  logic             r_par;

  logic w_clk_sync;
  logic w_clk_fall;
  logic w_dat_sync;
  logic w_dat_fall_unused;
  logic w_accept;
  logic w_timeout;

  ps2_sync_edge u_sync_clk (
    .i_clk  (clk_i),
    .i_rst  (rst_i),
    .i_line (ps2_clk_i),
    .o_sync (w_clk_sync),
    .o_fall (w_clk_fall)
  );

  ps2_sync_edge u_sync_dat (
    .i_clk  (clk_i),
    .i_rst  (rst_i),
    .i_line (ps2_dat_i),
    .o_sync (w_dat_sync),
    .o_fall (w_dat_fall_unused)
  );

  assign w_accept  = cmd_valid_i & cmd_ready_o;
  assign w_timeout = (r_to_cnt == TO_LAST);

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_data <= cmd_data_i;
      r_par  <= odd_parity(cmd_data_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_inh_cnt    <= '0;
      r_to_cnt     <= '0;
      r_bit        <= '0;
      r_ack_ok     <= 1'b0;
      ps2_clk_oe_o <= 1'b0;
      ps2_dat_oe_o <= 1'b0;
      cmd_ready_o  <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      done_o   <= 1'b0;
      error_o  <= 1'b0;
      r_to_cnt <= w_clk_fall ? '0 : r_to_cnt + 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_to_cnt <= '0;
          if (w_accept) begin
            r_state      <= ST_INHIBIT;
            r_inh_cnt    <= '0;
            ps2_clk_oe_o <= 1'b1;
            cmd_ready_o  <= 1'b0;
            busy_o       <= 1'b1;
          end
        end
        ST_INHIBIT: begin
          r_to_cnt  <= '0;
          r_inh_cnt <= r_inh_cnt + 1'b1;
          // Start bit goes out one cycle before the clock is released.
          if (r_inh_cnt == INH_START) ps2_dat_oe_o <= 1'b1;
          if (r_inh_cnt == INH_LAST) begin
            r_state      <= ST_REQ;
            r_inh_cnt    <= '0;
            ps2_clk_oe_o <= 1'b0;
          end
        end
        ST_REQ: begin
          if (w_clk_fall) begin
            r_state      <= ST_DATA;
            r_bit        <= '0;
            ps2_dat_oe_o <= ~r_data[0];
          end
        end
        ST_DATA: begin
          if (w_clk_fall) begin
            if (r_bit == 3'd7) begin
              r_state      <= ST_PARITY;
              ps2_dat_oe_o <= ~r_par;
            end else begin
              r_bit        <= r_bit + 3'd1;
              ps2_dat_oe_o <= ~r_data[r_bit + 3'd1];
            end
          end
        end
        ST_PARITY: begin
          if (w_clk_fall) begin
            r_state      <= ST_STOP;
            ps2_dat_oe_o <= 1'b0;
          end
        end
        ST_STOP: begin
          if (w_clk_fall) r_state <= ST_ACK;
        end
        ST_ACK: begin
          r_to_cnt <= '0;
          r_state  <= ST_WAIT_IDLE;
          r_ack_ok <= ~w_dat_sync;
          if (w_dat_sync) error_o <= 1'b1;
        end
        ST_WAIT_IDLE: begin
          if (w_clk_sync && w_dat_sync) begin
            r_state     <= ST_IDLE;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= r_ack_ok;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // A NACK already reported its error; a later timeout must not pulse again.
      if (w_timeout && (r_state != ST_IDLE) && (r_state != ST_INHIBIT)) begin
        r_state      <= ST_IDLE;
        r_to_cnt     <= '0;
        ps2_clk_oe_o <= 1'b0;
        ps2_dat_oe_o <= 1'b0;
        cmd_ready_o  <= 1'b1;
        busy_o       <= 1'b0;
        done_o       <= 1'b0;
        error_o      <= ~((r_state == ST_WAIT_IDLE) && !r_ack_ok);
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 keyboard model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 6000;
  localparam int TO  = 3000;
  localparam int H   = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       ready, clk_oe, dat_oe, busy, done, err;
  logic [10:0] bits;

  assign ps2_clk = ~clk_oe & dev_clk;
  assign ps2_dat = ~dat_oe & dev_dat;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_data_i   (cmd_data),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (ready),
    .ps2_clk_i    (ps2_clk),
    .ps2_dat_i    (ps2_dat),
    .ps2_clk_oe_o (clk_oe),
    .ps2_dat_oe_o (dat_oe),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Activity monitor, sampled 1 time unit after each rising edge.
  int   cyc = 0, n_done = 0, n_error = 0, n_acc = 0, n_ovl = 0, n_both = 0;
  int   low_run = 0, last_low = 0, t_req = 0, t_err = 0, t_done = 0, t_acc = 0;
  int   acc_at_done = 0;
  logic prev_ready = 1'b1, prev_clk_oe = 1'b0, err_busy = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst) begin
        if (done) begin n_done++; t_done = cyc; acc_at_done = n_acc; end
        if (err) begin n_error++; t_err = cyc; err_busy = busy; end
        if (done && err) n_both++;
        if (prev_ready && !ready) begin n_acc++; t_acc = cyc; end
        if (clk_oe && dat_oe) n_ovl++;
        if (clk_oe) low_run++;
        else if (low_run != 0) begin last_low = low_run; low_run = 0; end
        if (prev_clk_oe && !clk_oe && dat_oe) t_req = cyc;
      end else begin
        low_run = 0;
      end
      prev_ready  = ready;
      prev_clk_oe = clk_oe;
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog cycles=%0d limit=95000", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    cmd_data  = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Keyboard side: wait for request-to-send, then clock nedge falling edges,
  // capturing the data line just before each rising edge.
  task automatic dev_xfer(input logic ack, input int nedge);
    logic found;
    found = 1'b0;
    bits  = '0;
    for (int i = 0; i < 8000; i++) begin
      if (!clk_oe && dat_oe) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("req_seen", 32'(found), 32'd1);
    if (found) begin
      for (int k = 0; k < nedge; k++) begin
        repeat (H / 2) @(negedge clk);
        if (k == 10) dev_dat = !ack;
        repeat (H / 2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (H) @(negedge clk);
        bits[k] = ps2_dat;
        if (nedge == 11) dev_clk = 1'b1;
      end
      if (nedge == 11) begin
        repeat (H) @(negedge clk);
        dev_dat = 1'b1;
        repeat (H) @(negedge clk);
      end
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 2000; i++) begin
      if (ready) break;
      @(negedge clk);
    end
  endtask

  task automatic xfer(input string tag, input logic [7:0] b, input logic ack,
                      input logic exp_par);
    int d0, e0, o0;
    d0 = n_done; e0 = n_error; o0 = n_ovl;
    fork
      send_byte(b);
      dev_xfer(ack, 11);
    join
    wait_ready();
    repeat (2) @(negedge clk);
    check({tag, "_low"},     32'(last_low), 32'(INH));
    check({tag, "_start"},   32'(n_ovl - o0), 32'd1);
    check({tag, "_byte"},    32'(bits[7:0]), 32'(b));
    check({tag, "_par"},     32'(bits[8]), 32'(exp_par));
    check({tag, "_stop"},    32'(bits[9]), 32'd1);
    check({tag, "_ackline"}, 32'(bits[10]), ack ? 32'd0 : 32'd1);
    check({tag, "_done"},    32'(n_done - d0), ack ? 32'd1 : 32'd0);
    check({tag, "_err"},     32'(n_error - e0), ack ? 32'd0 : 32'd1);
    check({tag, "_ready"},   32'({ready, busy}), 32'b10);
    if (!ack) check({tag, "_busy_at_err"}, 32'(err_busy), 32'd1);
  endtask

  initial begin
    int d0, e0, a0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outs", 32'({clk_oe, dat_oe, ready, busy, done, err}), 32'b001000);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0xED: bits 1,0,1,1,0,1,1,1 (six ones) -> parity 1
    xfer("ed", PS2_CMD_SET_LEDS, 1'b1, 1'b1);
    // 0xF4: five ones -> parity 0
    xfer("f4", PS2_CMD_ENABLE, 1'b1, 1'b0);

    // Silent device: timeout after request-to-send
    d0 = n_done; e0 = n_error;
    send_byte(PS2_CMD_ENABLE);
    for (int i = 0; i < INH + TO + 100 && n_error == e0; i++) @(negedge clk);
    check("to_err",         32'(n_error - e0), 32'd1);
    check("to_time",        32'(t_err - t_req), 32'(TO));
    check("to_oe",          32'({clk_oe, dat_oe}), 32'b00);
    check("to_idle",        32'({ready, busy}), 32'b10);
    check("to_busy_at_err", 32'(err_busy), 32'd0);
    check("to_nodone",      32'(n_done - d0), 32'd0);

    // Device leaves data high at ACK time
    xfer("nack", PS2_CMD_SET_LEDS, 1'b0, 1'b1);

    // Reset while bit3 of 0xF4 (a zero, so data is driven low) is on the wire
    d0 = n_done; e0 = n_error;
    fork
      send_byte(PS2_CMD_ENABLE);
      dev_xfer(1'b1, 4);
    join
    check("mid_bit3_drive", 32'(dat_oe), 32'd1);
    check("mid_busy",       32'(busy), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_oe",    32'({clk_oe, dat_oe}), 32'b00);
    check("mid_rst_state", 32'({busy, ready, done, err}), 32'b0100);
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_nopulse", 32'((n_done - d0) + (n_error - e0)), 32'd0);
    // 0x00: zero ones -> parity 1
    xfer("zero", 8'h00, 1'b1, 1'b1);

    // cmd_valid held with 0xFF across the whole transfer
    d0 = n_done; a0 = n_acc;
    fork
      begin
        @(negedge clk);
        cmd_data  = PS2_CMD_RESET;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20000 && n_acc < a0 + 2; i++) @(negedge clk);
        cmd_valid = 1'b0;
      end
      begin
        dev_xfer(1'b1, 11);
        check("ff1_byte",      32'(bits[7:0]), 32'hFF);
        check("ff1_par",       32'(bits[8]), 32'd1);
        check("ff1_acc_busy",  32'(acc_at_done - a0), 32'd1);
        check("ff2_after_done", 32'(t_acc - t_done), 32'd1);
        dev_xfer(1'b1, 11);
      end
    join
    wait_ready();
    repeat (2) @(negedge clk);
    check("ff2_byte", 32'(bits[7:0]), 32'hFF);
    check("ff_acc",   32'(n_acc - a0), 32'd2);
    check("ff_done",  32'(n_done - d0), 32'd2);
    check("ff_ready", 32'({ready, busy}), 32'b10);

    check("no_dual_pulse", 32'(n_both), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
